// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: splits a 16-lane vector op into 4-element beats across
// four execution pipes, gathers in-order per-pipe results and issues one vreg write.
module vec_issue_seq #(
    parameter int NPIPE = 4,
    parameter int NLANE = 16,
    parameter int EW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ready,
    input  logic [1:0]          op,
    input  logic [4:0]          vl,
    input  logic [3:0]          dst,
    input  logic [NLANE*EW-1:0] va,
    input  logic [NLANE*EW-1:0] vb,
    input  logic [NLANE*EW-1:0] vold,
    input  logic                flush,
    output logic [NPIPE-1:0]    pipe_valid,
    output logic [1:0]          pipe_op,
    output logic [NPIPE*EW-1:0] pipe_a,
    output logic [NPIPE*EW-1:0] pipe_b,
    input  logic [NPIPE-1:0]    pipe_ready,
    input  logic [NPIPE-1:0]    res_valid,
    input  logic [NPIPE*EW-1:0] res_data,
    output logic                vwen,
    output logic [3:0]          vwaddr,
    output logic [NLANE*EW-1:0] vwdata,
    output logic                done,
    output logic [2:0]          state_dbg
);

    // Handshakes: an op transfers when start & ready; a beat transfers on every pipe
    // it uses in the one cycle all of those pipes are ready; res_valid is unconditional.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t state, state_d;

    logic [1:0]          op_q;
    logic [4:0]          vl_q;
    logic [3:0]          dst_q;
    logic [NLANE*EW-1:0] va_q, vb_q, buf_q;
    logic [1:0]          bt;
    logic [2:0]          icnt    [NPIPE];
    logic [2:0]          rcnt    [NPIPE];
    logic [2:0]          rcnt_nx [NPIPE];

    logic [NPIPE-1:0] active, res_ok;
    logic             all_rdy, beat_fire, last_beat, drain_done, flush_done, collecting;
    logic [4:0]       nbeats;

    always_comb begin
        active     = '0;
        res_ok     = '0;
        drain_done = 1'b1;
        flush_done = 1'b1;
        collecting = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_FLUSH);
        for (int p = 0; p < NPIPE; p++) begin
            active[p]  = ({1'b0, bt, 2'(p)} < vl_q);
            // A result with nothing outstanding on that pipe is dropped, not counted.
            res_ok[p]  = collecting && res_valid[p] && (rcnt[p] != icnt[p]);
            rcnt_nx[p] = rcnt[p] + {2'b00, res_ok[p]};
            if (rcnt_nx[p] != 3'((vl_q + 5'd3 - 5'(p)) >> 2)) drain_done = 1'b0;
            if (rcnt_nx[p] != icnt[p]) flush_done = 1'b0;
        end
        all_rdy   = &(pipe_ready | ~active);
        nbeats    = (vl_q + 5'd3) >> 2;
        last_beat = ({3'b000, bt} == nbeats - 5'd1);
        beat_fire = (state == S_ISSUE) && all_rdy && !flush;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = (vl == 5'd0) ? S_WRITE : S_ISSUE;
            S_ISSUE: begin
                if (flush)                       state_d = S_FLUSH;
                else if (beat_fire && last_beat) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush)           state_d = S_FLUSH;
                else if (drain_done) state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_FLUSH: if (flush_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == S_IDLE);
        pipe_valid = beat_fire ? active : '0;
        pipe_op    = (state == S_ISSUE) ? op_q : 2'b00;
        pipe_a     = '0;
        pipe_b     = '0;
        if (state == S_ISSUE) begin
            for (int p = 0; p < NPIPE; p++) begin
                pipe_a[p*EW +: EW] = va_q[int'({bt, 2'(p)})*EW +: EW];
                pipe_b[p*EW +: EW] = vb_q[int'({bt, 2'(p)})*EW +: EW];
            end
        end
        vwen      = (state == S_WRITE) && (vl_q != 5'd0);
        vwaddr    = (state == S_WRITE) ? dst_q : 4'd0;
        vwdata    = (state == S_WRITE) ? buf_q : '0;
        done      = (state == S_WRITE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            vl_q  <= '0;
            dst_q <= '0;
            va_q  <= '0;
            vb_q  <= '0;
            buf_q <= '0;
            bt    <= '0;
            for (int p = 0; p < NPIPE; p++) begin
                icnt[p] <= '0;
                rcnt[p] <= '0;
            end
        end else if (state == S_IDLE) begin
            if (start) begin
                op_q  <= op;
                vl_q  <= (vl > 5'd16) ? 5'd16 : vl;
                dst_q <= dst;
                va_q  <= va;
                vb_q  <= vb;
                buf_q <= vold;
                bt    <= '0;
                for (int p = 0; p < NPIPE; p++) begin
                    icnt[p] <= '0;
                    rcnt[p] <= '0;
                end
            end
        end else begin
            if (beat_fire) begin
                bt <= bt + 2'd1;
                for (int p = 0; p < NPIPE; p++)
                    if (active[p]) icnt[p] <= icnt[p] + 3'd1;
            end
            // Pipe p's n-th result belongs to element 4n+p; flushed results are only counted.
            for (int p = 0; p < NPIPE; p++) begin
                if (res_ok[p]) begin
                    rcnt[p] <= rcnt_nx[p];
                    if (state != S_FLUSH)
                        buf_q[int'({rcnt[p][1:0], 2'(p)})*EW +: EW] <= res_data[p*EW +: EW];
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed testbench for vec_issue_seq with a behavioural per-pipe latency model.
module tb_vec_issue_seq;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic         ready, vwen, done;
  logic [1:0]   op, pipe_op;
  logic [4:0]   vl;
  logic [3:0]   dst, vwaddr;
  logic [255:0] va, vb, vold, vwdata;
  logic [3:0]   pipe_valid, pipe_ready, res_valid;
  logic [63:0]  pipe_a, pipe_b, res_data;
  logic [2:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;
  int unsigned lat [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_issue_seq dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .op(op), .vl(vl), .dst(dst),
    .va(va), .vb(vb), .vold(vold), .flush(flush), .pipe_valid(pipe_valid),
    .pipe_op(pipe_op), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_ready(pipe_ready),
    .res_valid(res_valid), .res_data(res_data), .vwen(vwen), .vwaddr(vwaddr),
    .vwdata(vwdata), .done(done), .state_dbg(state_dbg)
  );

  function automatic logic [15:0] alu(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    prod = a * b;
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return prod[15:0];
      default: return (b == 16'd0) ? 16'hFFFF : a / b;
    endcase
  endfunction

  // Pipe model: in-order results, each pipe with its own latency in cycles.
  for (genvar g = 0; g < 4; g++) begin : g_pipe
    int unsigned due_q[$];
    logic [15:0] dat_q[$];
    logic        rv = 1'b0;
    logic [15:0] rd = 16'd0;
    assign res_valid[g] = rv;
    assign res_data[g*16 +: 16] = rd;
    always @(negedge clk) begin
      if (rv) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (pipe_valid[g]) begin
        due_q.push_back(cyc + lat[g]);
        dat_q.push_back(alu(pipe_op, pipe_a[g*16 +: 16], pipe_b[g*16 +: 16]));
      end
    end
    always @(posedge clk) begin
      #1;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        rv = 1'b1;
        rd = dat_q[0];
      end else begin
        rv = 1'b0;
        rd = 16'd0;
      end
    end
  end

  // Per-cycle observations of one op, index k = cycles after acceptance.
  logic [3:0]   pv_log [64];
  logic [63:0]  pa_log [64];
  logic [2:0]   st_log [64];
  int           done_cyc, ready_cyc, n_wen, n_done, n_res, n_pv, last_res_cyc;
  logic         w_en;
  logic [3:0]   w_addr;
  logic [255:0] w_data;

  task automatic issue_op(input logic [1:0] o, input logic [4:0] l, input logic [3:0] d,
                          input logic [255:0] a, input logic [255:0] b, input logic [255:0] old);
    op = o; vl = l; dst = d; va = a; vb = b; vold = old; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic watch(input int budget, input int flush_at, input int stall_from,
                       input int stall_to, input logic [3:0] stall_mask);
    int  k;
    bit  stop;
    for (int i = 0; i < 64; i++) begin
      pv_log[i] = '0; pa_log[i] = '0; st_log[i] = '0;
    end
    done_cyc = -1; ready_cyc = -1; n_wen = 0; n_done = 0; n_res = 0; n_pv = 0;
    last_res_cyc = -1; w_en = 1'b0; w_addr = '0; w_data = '0;
    k = 1;
    stop = 1'b0;
    while (k <= budget && !stop) begin
      flush = (k == flush_at);
      pipe_ready = (k >= stall_from && k <= stall_to) ? stall_mask : 4'hF;
      @(negedge clk);
      pv_log[k] = pipe_valid;
      pa_log[k] = pipe_a;
      st_log[k] = state_dbg;
      if (pipe_valid != 4'h0) n_pv++;
      if (res_valid != 4'h0) begin
        n_res += $countones(res_valid);
        last_res_cyc = k;
      end
      if (vwen) n_wen++;
      if (done) begin
        n_done++;
        done_cyc = k; w_en = vwen; w_addr = vwaddr; w_data = vwdata;
      end
      if (ready) begin
        ready_cyc = k;
        stop = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    flush = 1'b0;
    pipe_ready = 4'hF;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b exp 1", ready); end
    n_checks++; if ({pipe_valid, vwen, done} !== 6'b0) begin n_errors++; $display("FAIL reset_strobes: got %b exp 000000", {pipe_valid, vwen, done}); end
    n_checks++; if ({pipe_op, pipe_a, pipe_b, vwaddr} !== '0) begin n_errors++; $display("FAIL reset_pipe_bus: got %h exp 0", {pipe_op, pipe_a, pipe_b, vwaddr}); end
    n_checks++; if (vwdata !== '0) begin n_errors++; $display("FAIL reset_vwdata: got %h exp 0", vwdata); end
    n_checks++; if (state_dbg !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_full;
    logic [255:0] a, b, e;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16] = 16'(i); b[i*16 +: 16] = 16'd100; e[i*16 +: 16] = 16'(100 + i);
    end
    issue_op(2'd0, 5'd16, 4'd5, a, b, '0);
    watch(40, -1, -1, -1, 4'hF);
    n_checks++; if ({pv_log[1], pv_log[2], pv_log[3], pv_log[4], pv_log[5]} !== 20'hFFFF0) begin n_errors++; $display("FAIL full_beats: got %h exp ffff0", {pv_log[1], pv_log[2], pv_log[3], pv_log[4], pv_log[5]}); end
    n_checks++; if (pa_log[2] !== 64'h0007_0006_0005_0004) begin n_errors++; $display("FAIL full_beat1_lanes: got %h exp 0007000600050004", pa_log[2]); end
    n_checks++; if (done_cyc !== 6) begin n_errors++; $display("FAIL full_write_cycle: got %0d exp 6", done_cyc); end
    n_checks++; if ({w_en, w_addr} !== 5'b1_0101) begin n_errors++; $display("FAIL full_wen_addr: got %b exp 10101", {w_en, w_addr}); end
    n_checks++; if (w_data !== e) begin n_errors++; $display("FAIL full_data: got %h exp %h", w_data, e); end
    n_checks++; if (ready_cyc !== 7) begin n_errors++; $display("FAIL full_ready_cycle: got %0d exp 7", ready_cyc); end
  endtask

  task automatic test_partial;
    logic [255:0] a, b, old, e;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16] = 16'(16'h0100 + i); b[i*16 +: 16] = 16'(2 * i);
      old[i*16 +: 16] = 16'hBEEF;
      e[i*16 +: 16] = (i < 6) ? 16'(16'h0100 - i) : 16'hBEEF;
    end
    issue_op(2'd1, 5'd6, 4'd9, a, b, old);
    watch(40, -1, -1, -1, 4'hF);
    n_checks++; if ({pv_log[1], pv_log[2], pv_log[3]} !== 12'hF30) begin n_errors++; $display("FAIL partial_beats: got %h exp f30", {pv_log[1], pv_log[2], pv_log[3]}); end
    n_checks++; if (done_cyc !== 4) begin n_errors++; $display("FAIL partial_write_cycle: got %0d exp 4", done_cyc); end
    n_checks++; if ({w_en, w_addr} !== 5'b1_1001) begin n_errors++; $display("FAIL partial_wen_addr: got %b exp 11001", {w_en, w_addr}); end
    n_checks++; if (w_data !== e) begin n_errors++; $display("FAIL partial_data: got %h exp %h", w_data, e); end
  endtask

  task automatic test_stall;
    logic [255:0] a, b, e;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16] = 16'(16'h0111 * i); b[i*16 +: 16] = 16'h0F0F;
      e[i*16 +: 16] = 16'(16'h0111 * i + 16'h0F0F);
    end
    issue_op(2'd0, 5'd16, 4'd3, a, b, '0);
    watch(40, -1, 2, 4, 4'b1011);
    n_checks++; if ({pv_log[2], pv_log[3], pv_log[4]} !== 12'h000) begin n_errors++; $display("FAIL stall_hold: got %h exp 000", {pv_log[2], pv_log[3], pv_log[4]}); end
    n_checks++; if (pv_log[5] !== 4'hF) begin n_errors++; $display("FAIL stall_release: got %b exp 1111", pv_log[5]); end
    n_checks++; if (done_cyc !== 9) begin n_errors++; $display("FAIL stall_write_cycle: got %0d exp 9", done_cyc); end
    n_checks++; if (w_data !== e) begin n_errors++; $display("FAIL stall_data: got %h exp %h", w_data, e); end
  endtask

  task automatic test_unequal;
    logic [255:0] a, b, e;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16] = 16'(16'h1000 + i); b[i*16 +: 16] = 16'(16'h0020 * i);
      e[i*16 +: 16] = 16'(16'h1000 + 16'h0021 * i);
    end
    lat[0] = 5;
    issue_op(2'd0, 5'd16, 4'd7, a, b, '0);
    watch(40, -1, -1, -1, 4'hF);
    lat[0] = 1;
    n_checks++; if ({st_log[5], st_log[9]} !== 6'o22) begin n_errors++; $display("FAIL unequal_drain_states: got %o exp 22", {st_log[5], st_log[9]}); end
    n_checks++; if (done_cyc !== 10) begin n_errors++; $display("FAIL unequal_write_cycle: got %0d exp 10", done_cyc); end
    n_checks++; if ({w_data[192 +: 16], w_data[128 +: 16], w_data[64 +: 16], w_data[0 +: 16]} !== 64'h118C_1108_1084_1000) begin n_errors++; $display("FAIL unequal_pipe0_lanes: got %h exp 118c110810841000", {w_data[192 +: 16], w_data[128 +: 16], w_data[64 +: 16], w_data[0 +: 16]}); end
    n_checks++; if (w_data !== e) begin n_errors++; $display("FAIL unequal_data: got %h exp %h", w_data, e); end
  endtask

  task automatic test_flush;
    for (int p = 0; p < 4; p++) lat[p] = 4;
    issue_op(2'd0, 5'd16, 4'd4, {16{16'h0003}}, {16{16'h0004}}, '0);
    watch(40, 3, -1, -1, 4'hF);
    for (int p = 0; p < 4; p++) lat[p] = 1;
    n_checks++; if ({pv_log[1], pv_log[2], n_pv} !== {8'hFF, 32'd2}) begin n_errors++; $display("FAIL flush_issue_stop: got %h %h beats %0d exp ff beats 2", pv_log[1], pv_log[2], n_pv); end
    n_checks++; if (st_log[4] !== 3'd4) begin n_errors++; $display("FAIL flush_state: got %0d exp 4", st_log[4]); end
    n_checks++; if ({n_wen, n_done} !== {32'd0, 32'd0}) begin n_errors++; $display("FAIL flush_no_write: got wen %0d done %0d exp 0 0", n_wen, n_done); end
    n_checks++; if ({n_res, last_res_cyc} !== {32'd8, 32'd6}) begin n_errors++; $display("FAIL flush_results: got %0d at %0d exp 8 at 6", n_res, last_res_cyc); end
    n_checks++; if (ready_cyc !== 7) begin n_errors++; $display("FAIL flush_ready_cycle: got %0d exp 7", ready_cyc); end
  endtask

  task automatic test_vl_zero;
    issue_op(2'd0, 5'd0, 4'd2, {16{16'h1111}}, {16{16'h2222}}, {16{16'h3333}});
    watch(10, -1, -1, -1, 4'hF);
    n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL vl0_done_cycle: got %0d exp 1", done_cyc); end
    n_checks++; if ({w_en, n_wen, n_pv} !== {1'b0, 32'd0, 32'd0}) begin n_errors++; $display("FAIL vl0_no_activity: got wen %b/%0d beats %0d exp 0 0 0", w_en, n_wen, n_pv); end
    n_checks++; if (ready_cyc !== 2) begin n_errors++; $display("FAIL vl0_ready_cycle: got %0d exp 2", ready_cyc); end
  endtask

  task automatic test_vl_clamp;
    logic [255:0] a, e;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16] = 16'(16'h2000 + i); e[i*16 +: 16] = 16'(16'h2001 + i);
    end
    issue_op(2'd0, 5'd20, 4'd11, a, {16{16'h0001}}, {16{16'hDEAD}});
    watch(40, -1, -1, -1, 4'hF);
    n_checks++; if ({pv_log[4], pv_log[5], done_cyc} !== {8'hF0, 32'd6}) begin n_errors++; $display("FAIL clamp_beats: got %h %h done %0d exp f 0 done 6", pv_log[4], pv_log[5], done_cyc); end
    n_checks++; if (w_data !== e) begin n_errors++; $display("FAIL clamp_data: got %h exp %h", w_data, e); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] a, e1, b2, e2;
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16]  = 16'(i + 1);
      e1[i*16 +: 16] = (i < 4) ? 16'(i + 16'h11) : 16'hAAAA;
      b2[i*16 +: 16] = 16'(i);
      e2[i*16 +: 16] = (i < 8) ? 16'(16'h0050 - i) : 16'h5555;
    end
    issue_op(2'd0, 5'd4, 4'd1, a, {16{16'h0010}}, {16{16'hAAAA}});
    watch(20, -1, -1, -1, 4'hF);
    n_checks++; if ({done_cyc, ready_cyc} !== {32'd3, 32'd4}) begin n_errors++; $display("FAIL b2b_first_timing: got done %0d ready %0d exp 3 4", done_cyc, ready_cyc); end
    n_checks++; if (w_data !== e1) begin n_errors++; $display("FAIL b2b_first_data: got %h exp %h", w_data, e1); end
    issue_op(2'd1, 5'd8, 4'd2, {16{16'h0050}}, b2, {16{16'h5555}});
    watch(20, -1, -1, -1, 4'hF);
    n_checks++; if ({done_cyc, w_addr} !== {32'd4, 4'd2}) begin n_errors++; $display("FAIL b2b_second_write: got done %0d addr %0d exp 4 2", done_cyc, w_addr); end
    n_checks++; if (w_data !== e2) begin n_errors++; $display("FAIL b2b_second_data: got %h exp %h", w_data, e2); end
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    lat[0] = 5;
    issue_op(2'd0, 5'd16, 4'd6, {16{16'h0042}}, {16{16'h0001}}, '0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++; if (state_dbg !== 3'd2) begin n_errors++; $display("FAIL rstmid_in_drain: got %0d exp 2", state_dbg); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if ({ready, pipe_valid, vwen, done, state_dbg} !== 10'b1_0000_0_0_000) begin n_errors++; $display("FAIL rstmid_ctrl: got %b exp 1000000000", {ready, pipe_valid, vwen, done, state_dbg}); end
    n_checks++; if ({pipe_op, pipe_a, pipe_b, vwaddr, vwdata} !== '0) begin n_errors++; $display("FAIL rstmid_data: got %h exp 0", {pipe_op, pipe_a, pipe_b, vwaddr, vwdata}); end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!ready || vwen || done || pipe_valid != 4'h0) bad++;
    end
    lat[0] = 1;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rstmid_stale_results: got %0d bad cycles exp 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int p = 0; p < 4; p++) lat[p] = 1;
    rst = 1'b1; start = 1'b0; flush = 1'b0; pipe_ready = 4'hF;
    op = '0; vl = '0; dst = '0; va = '0; vb = '0; vold = '0;
    test_reset;
    test_full;
    test_partial;
    test_stall;
    test_unequal;
    test_flush;
    test_vl_zero;
    test_vl_clamp;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
